// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator: syncs, active qualifier, pixel addresses, frame/line strobes.
// Outputs lag the counters by 1+PIX_LAT pixel ticks; optional frame counter under VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_SYNC   = 112,
    parameter int H_BACK   = 248,
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 48,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 38,
    parameter int V_ACTIVE = 1024,
    parameter int V_FRONT  = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int ADDR_W   = 11,
    parameter int PIX_LAT  = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Pix_En,
    input  logic              Run,
    output logic              Busy_Sig,
    output logic              HSYNC_Sig,
    output logic              VSYNC_Sig,
    output logic              Ready_Sig,
    output logic [ADDR_W-1:0] Column_Addr_Sig,
    output logic [ADDR_W-1:0] Row_Addr_Sig,
    output logic              Frame_Start_Sig,
    output logic              Line_Start_Sig
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]       Frame_Cnt_Sig
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [ADDR_W-1:0] L_H_LAST   = ADDR_W'(H_TOTAL - 1);
    localparam logic [ADDR_W-1:0] L_V_LAST   = ADDR_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] L_HS_END   = ADDR_W'(H_SYNC);
    localparam logic [ADDR_W-1:0] L_VS_END   = ADDR_W'(V_SYNC);
    localparam logic [ADDR_W-1:0] L_HA0      = ADDR_W'(H_SYNC + H_BACK);
    localparam logic [ADDR_W-1:0] L_HA_LAST  = ADDR_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] L_VA0      = ADDR_W'(V_SYNC + V_BACK);
    localparam logic [ADDR_W-1:0] L_VA_LAST  = ADDR_W'(V_SYNC + V_BACK + V_ACTIVE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

    typedef struct packed {
        logic              hs;
        logic              vs;
        logic              rdy;
        logic [ADDR_W-1:0] col;
        logic [ADDR_W-1:0] row;
        logic              fs;
        logic              ls;
    } dec_t;

    localparam dec_t DEC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, rdy: 1'b0,
                                  col: {ADDR_W{1'b0}}, row: {ADDR_W{1'b0}},
                                  fs: 1'b0, ls: 1'b0};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt_h;
    logic [ADDR_W-1:0] r_cnt_v;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_busy;
    logic              w_h_act;
    logic              w_v_act;
    dec_t              w_dec;
    dec_t              r_pipe [0:PIX_LAT];

    assign w_h_last = (r_cnt_h == L_H_LAST);
    assign w_v_last = (r_cnt_v == L_V_LAST);
    assign w_busy   = (r_state != S_IDLE);

    // Stopping is only honoured on the last tick of a frame so a frame is never cut short.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (Run) w_state_nxt = S_RUN;
            S_RUN:      if (!Run) w_state_nxt = S_STOPPING;
            S_STOPPING: begin
                if (Run)
                    w_state_nxt = S_RUN;
                else if (w_h_last && w_v_last)
                    w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (Pix_En) begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_cnt_h <= '0;
                r_cnt_v <= '0;
            end else if (w_h_last) begin
                r_cnt_h <= '0;
                r_cnt_v <= w_v_last ? '0 : r_cnt_v + ADDR_W'(1);
            end else begin
                r_cnt_h <= r_cnt_h + ADDR_W'(1);
            end
        end
    end

    assign w_h_act = (r_cnt_h >= L_HA0) && (r_cnt_h <= L_HA_LAST);
    assign w_v_act = (r_cnt_v >= L_VA0) && (r_cnt_v <= L_VA_LAST);

    always_comb begin
        w_dec = DEC_IDLE;
        if (w_busy) begin
            w_dec.hs  = (r_cnt_h < L_HS_END) ? HS_POL : ~HS_POL;
            w_dec.vs  = (r_cnt_v < L_VS_END) ? VS_POL : ~VS_POL;
            w_dec.rdy = w_h_act && w_v_act;
            if (w_h_act && w_v_act) begin
                w_dec.col = r_cnt_h - L_HA0;
                w_dec.row = r_cnt_v - L_VA0;
            end
            w_dec.fs  = (r_cnt_h == '0) && (r_cnt_v == '0);
            w_dec.ls  = (r_cnt_h == '0);
        end
    end

    // Stage 0 is the decode register; stages 1..PIX_LAT match downstream pixel-pipeline depth.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i <= PIX_LAT; i++) r_pipe[i] <= DEC_IDLE;
        end else if (Pix_En) begin
            r_pipe[0] <= w_dec;
            for (int i = 1; i <= PIX_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign Busy_Sig        = w_busy;
    assign HSYNC_Sig       = r_pipe[PIX_LAT].hs;
    assign VSYNC_Sig       = r_pipe[PIX_LAT].vs;
    assign Ready_Sig       = r_pipe[PIX_LAT].rdy;
    assign Column_Addr_Sig = r_pipe[PIX_LAT].col;
    assign Row_Addr_Sig    = r_pipe[PIX_LAT].row;
    assign Frame_Start_Sig = r_pipe[PIX_LAT].fs;
    assign Line_Start_Sig  = r_pipe[PIX_LAT].ls;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_frame_cnt <= '0;
        else if (Pix_En && w_dec.fs)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign Frame_Cnt_Sig = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small modes at PIX_LAT 0/4, HS_POL=1, default mode sync widths.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    logic run = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic        s0_busy, s0_hs, s0_vs, s0_rdy, s0_fs, s0_ls;
    logic [10:0] s0_col, s0_row;
    logic        s4_busy, s4_hs, s4_vs, s4_rdy, s4_fs, s4_ls;
    logic [10:0] s4_col, s4_row;
    logic        hp_busy, hp_hs, hp_vs, hp_rdy, hp_fs, hp_ls;
    logic [10:0] hp_col, hp_row;
    logic        df_busy, df_hs, df_vs, df_rdy, df_fs, df_ls;
    logic [10:0] df_col, df_row;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] s0_fcnt, s4_fcnt, hp_fcnt, df_fcnt;
`endif

    vga_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
                     .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .PIX_LAT(0))
    u_s0 (.CLK(clk), .RSTn(rst_n), .Pix_En(pix_en), .Run(run), .Busy_Sig(s0_busy),
          .HSYNC_Sig(s0_hs), .VSYNC_Sig(s0_vs), .Ready_Sig(s0_rdy), .Column_Addr_Sig(s0_col),
          .Row_Addr_Sig(s0_row), .Frame_Start_Sig(s0_fs), .Line_Start_Sig(s0_ls)
`ifdef VGA_TIMING_FRAME_CNT_EN
          , .Frame_Cnt_Sig(s0_fcnt)
`endif
         );

    vga_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
                     .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .PIX_LAT(4))
    u_s4 (.CLK(clk), .RSTn(rst_n), .Pix_En(pix_en), .Run(run), .Busy_Sig(s4_busy),
          .HSYNC_Sig(s4_hs), .VSYNC_Sig(s4_vs), .Ready_Sig(s4_rdy), .Column_Addr_Sig(s4_col),
          .Row_Addr_Sig(s4_row), .Frame_Start_Sig(s4_fs), .Line_Start_Sig(s4_ls)
`ifdef VGA_TIMING_FRAME_CNT_EN
          , .Frame_Cnt_Sig(s4_fcnt)
`endif
         );

    vga_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
                     .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
                     .HS_POL(1'b1), .PIX_LAT(0))
    u_hp (.CLK(clk), .RSTn(rst_n), .Pix_En(pix_en), .Run(run), .Busy_Sig(hp_busy),
          .HSYNC_Sig(hp_hs), .VSYNC_Sig(hp_vs), .Ready_Sig(hp_rdy), .Column_Addr_Sig(hp_col),
          .Row_Addr_Sig(hp_row), .Frame_Start_Sig(hp_fs), .Line_Start_Sig(hp_ls)
`ifdef VGA_TIMING_FRAME_CNT_EN
          , .Frame_Cnt_Sig(hp_fcnt)
`endif
         );

    vga_timing_gen u_df (.CLK(clk), .RSTn(rst_n), .Pix_En(pix_en), .Run(run), .Busy_Sig(df_busy),
          .HSYNC_Sig(df_hs), .VSYNC_Sig(df_vs), .Ready_Sig(df_rdy), .Column_Addr_Sig(df_col),
          .Row_Addr_Sig(df_row), .Frame_Start_Sig(df_fs), .Line_Start_Sig(df_ls)
`ifdef VGA_TIMING_FRAME_CNT_EN
          , .Frame_Cnt_Sig(df_fcnt)
`endif
         );

    // Output vectors: {hs, vs, rdy, col, row, fs, ls}
    logic [26:0] s0_v, s4_v, hp_v, df_v;
    assign s0_v = {s0_hs, s0_vs, s0_rdy, s0_col, s0_row, s0_fs, s0_ls};
    assign s4_v = {s4_hs, s4_vs, s4_rdy, s4_col, s4_row, s4_fs, s4_ls};
    assign hp_v = {hp_hs, hp_vs, hp_rdy, hp_col, hp_row, hp_fs, hp_ls};
    assign df_v = {df_hs, df_vs, df_rdy, df_col, df_row, df_fs, df_ls};

    // Small mode: H 2/3/8/2 (total 15), V 1/1/4/1 (total 7); p is the linear counter position.
    function automatic logic [26:0] small_exp(input int p, input bit hpol);
        int h, v;
        logic hs, vs, rdy, fs, ls;
        logic [10:0] col, row;
        if (p < 0) return {~hpol, 1'b1, 25'd0};
        h   = p % 15;
        v   = (p / 15) % 7;
        hs  = (h < 2) ? hpol : ~hpol;
        vs  = (v < 1) ? 1'b0 : 1'b1;
        rdy = (h >= 5) && (h < 13) && (v >= 2) && (v < 6);
        col = rdy ? 11'(h - 5) : 11'd0;
        row = rdy ? 11'(v - 2) : 11'd0;
        fs  = (h == 0) && (v == 0);
        ls  = (h == 0);
        return {hs, vs, rdy, col, row, fs, ls};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b1;
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s0_busy, s0_v} !== {1'b0, 1'b1, 1'b1, 25'd0}) begin
            errors++; $display("FAIL reset_s0 got=%h exp=%h", {s0_busy, s0_v}, {1'b0, 1'b1, 1'b1, 25'd0});
        end
        checks++;
        if ({s4_busy, s4_v} !== {1'b0, 1'b1, 1'b1, 25'd0}) begin
            errors++; $display("FAIL reset_s4 got=%h exp=%h", {s4_busy, s4_v}, {1'b0, 1'b1, 1'b1, 25'd0});
        end
        checks++;
        if ({hp_busy, hp_v} !== {1'b0, 1'b0, 1'b1, 25'd0}) begin
            errors++; $display("FAIL reset_hp got=%h exp=%h", {hp_busy, hp_v}, {1'b0, 1'b0, 1'b1, 25'd0});
        end
        checks++;
        if ({df_busy, df_v} !== {1'b0, 1'b1, 1'b1, 25'd0}) begin
            errors++; $display("FAIL reset_df got=%h exp=%h", {df_busy, df_v}, {1'b0, 1'b1, 1'b1, 25'd0});
        end
    endtask

    // Run=1 from reset; Pix_En high on every div-th clock. k counts pixel ticks since reset release.
    task automatic test_small_run(input int div);
        int k = 0;
        logic [26:0] e0, e4, eh;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= div * 220; c++) begin
            pix_en = (c % div == 0);
            @(posedge clk);
            #1;
            if (pix_en) k++;
            e0 = small_exp(k - 2, 1'b0);
            e4 = small_exp(k - 6, 1'b0);
            eh = small_exp(k - 2, 1'b1);
            checks++;
            if ({s0_busy, s0_v} !== {(k >= 1), e0}) begin
                errors++; $display("FAIL run_s0 div=%0d k=%0d got=%h exp=%h", div, k, {s0_busy, s0_v}, {(k >= 1), e0});
            end
            checks++;
            if ({s4_busy, s4_v} !== {(k >= 1), e4}) begin
                errors++; $display("FAIL run_s4 div=%0d k=%0d got=%h exp=%h", div, k, {s4_busy, s4_v}, {(k >= 1), e4});
            end
            checks++;
            if ({hp_busy, hp_v} !== {(k >= 1), eh}) begin
                errors++; $display("FAIL run_hp div=%0d k=%0d got=%h exp=%h", div, k, {hp_busy, hp_v}, {(k >= 1), eh});
            end
            if (div == 1 && (k == 36 || k == 37 || k == 89 || k == 90)) begin
                // Hand values: first active pixel after counter (5,2), last at (12,5) = col 7 row 3.
                checks++;
                if ({s0_rdy, s0_col, s0_row} !== ((k == 37) ? {1'b1, 11'd0, 11'd0} :
                                                  (k == 89) ? {1'b1, 11'd7, 11'd3} : 23'd0)) begin
                    errors++; $display("FAIL edge_pixel k=%0d got rdy=%b col=%0d row=%0d", k, s0_rdy, s0_col, s0_row);
                end
            end
        end
        pix_en = 1'b1;
    endtask

    // Run dropped with counter at (4,3); restarted after a few idle ticks.
    task automatic test_stop_restart();
        logic [26:0] e0, e4;
        logic eb;
        do_reset();
        for (int k = 1; k <= 220; k++) begin
            run = (k < 51) || (k >= 111);
            @(posedge clk);
            #1;
            eb = (k <= 105) || (k >= 111);
            e0 = (k - 112 >= 0) ? small_exp(k - 112, 1'b0) :
                 (k - 2 <= 104) ? small_exp(k - 2, 1'b0) : small_exp(-1, 1'b0);
            e4 = (k - 116 >= 0) ? small_exp(k - 116, 1'b0) :
                 (k - 6 <= 104) ? small_exp(k - 6, 1'b0) : small_exp(-1, 1'b0);
            checks++;
            if ({s0_busy, s0_v} !== {eb, e0}) begin
                errors++; $display("FAIL stop_s0 k=%0d got=%h exp=%h", k, {s0_busy, s0_v}, {eb, e0});
            end
            checks++;
            if ({s4_busy, s4_v} !== {eb, e4}) begin
                errors++; $display("FAIL stop_s4 k=%0d got=%h exp=%h", k, {s4_busy, s4_v}, {eb, e4});
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1;
        repeat (40) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({s0_busy, s0_v, s4_busy, s4_v} !== {1'b0, 1'b1, 1'b1, 25'd0, 1'b0, 1'b1, 1'b1, 25'd0}) begin
            errors++; $display("FAIL async_rst s0=%h s4=%h exp idle", {s0_busy, s0_v}, {s4_busy, s4_v});
        end
        checks++;
        if ({hp_busy, hp_v, df_busy, df_v} !== {1'b0, 1'b0, 1'b1, 25'd0, 1'b0, 1'b1, 1'b1, 25'd0}) begin
            errors++; $display("FAIL async_rst hp=%h df=%h exp idle", {hp_busy, hp_v}, {df_busy, df_v});
        end
        run = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({s4_busy, s4_v} !== {1'b0, 1'b1, 1'b1, 25'd0}) begin
                errors++; $display("FAIL post_rst_idle k=%0d got=%h exp=%h", k, {s4_busy, s4_v}, {1'b0, 1'b1, 1'b1, 25'd0});
            end
        end
        run = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({s0_fs, s0_ls, s4_fs} !== {(k == 2), (k == 2), (k == 6)}) begin
                errors++; $display("FAIL post_rst_start k=%0d got=%b exp=%b", k, {s0_fs, s0_ls, s4_fs}, {(k == 2), (k == 2), (k == 6)});
            end
        end
    endtask

    // Default 1688 x 1066 mode: first three lines only.
    task automatic test_default_timing();
        int hs0 = 0, hs1 = 0, vsl = 0, rdyc = 0, p;
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 5102; k++) begin
            @(posedge clk);
            #1;
            p = k - 2;
            if (p >= 0 && p < 1688 && df_hs == 1'b0) hs0++;
            if (p >= 1688 && p < 3376 && df_hs == 1'b0) hs1++;
            if (p >= 0 && df_vs == 1'b0) vsl++;
            if (df_rdy) rdyc++;
            if (p == 0 || p == 112 || p == 1688 || p == 5064) begin
                checks++;
                if ({df_hs, df_vs, df_fs, df_ls} !== ((p == 0)    ? 4'b0011 :
                                                     (p == 112)  ? 4'b1000 :
                                                     (p == 1688) ? 4'b0001 : 4'b0101)) begin
                    errors++; $display("FAIL def_spot p=%0d got hs,vs,fs,ls=%b", p, {df_hs, df_vs, df_fs, df_ls});
                end
            end
        end
        checks++;
        if (hs0 !== 112) begin errors++; $display("FAIL def_hs_line0 got=%0d exp=112", hs0); end
        checks++;
        if (hs1 !== 112) begin errors++; $display("FAIL def_hs_line1 got=%0d exp=112", hs1); end
        checks++;
        if (vsl !== 5064) begin errors++; $display("FAIL def_vs_low got=%0d exp=5064", vsl); end
        checks++;
        if (rdyc !== 0) begin errors++; $display("FAIL def_rdy_blank got=%0d exp=0", rdyc); end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        logic [15:0] ef;
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 215; k++) begin
            @(posedge clk);
            #1;
            ef = (k >= 212) ? 16'd3 : (k >= 107) ? 16'd2 : (k >= 2) ? 16'd1 : 16'd0;
            checks++;
            if ({s0_fcnt, s4_fcnt} !== {ef, ef}) begin
                errors++; $display("FAIL frame_cnt k=%0d got s0=%0d s4=%0d exp=%0d", k, s0_fcnt, s4_fcnt, ef);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_small_run(1);
        test_small_run(3);
        test_stop_restart();
        test_async_reset();
        test_default_timing();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
